// File: rtl/pbit_gibbs_sched.sv
// pbit_gibbs_sched
//   Sequential Gibbs-sampling scheduler. One shared pbit datapath (tanh, RNG,
//   compare) is time-shared across N logical p-bits. For each p-bit in turn the
//   bias and coupling row are read from an external coefficient RAM, the local
//   field is accumulated in Q(INT_SIZE).(FLOAT_SIZE), presented to the pbit, and
//   the pbit result is written back as the new spin. A run covers num_sweeps
//   full sweeps and ends with a one-cycle done pulse.
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   start       single-cycle run request, accepted only when idle
//   num_sweeps  sweeps to run, sampled on an accepted start
//   init_state  initial spin vector, sampled on an accepted start
//   coef_rd     coefficient read strobe
//   coef_addr   coefficient address (row i at i*(N+1); word 0 bias, 1..N J_ij)
//   coef_data   signed coefficient, valid one cycle after coef_rd
//   z           saturated signed local field driven to the pbit
//   z_valid     high while z is held for the pbit
//   pbit_val    pbit output, sampled PBIT_LAT cycles after z is presented
//   state       current spin vector (1 = +1, 0 = -1)
//   busy        run in progress
//   done        one-cycle end-of-run pulse
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | coef_rd high, stepping through the N+1 words of row i
// DRAIN  | last word returns; z and z_valid are loaded
// SETTLE | z held for PBIT_LAT cycles while the pbit pipeline fills
// LATCH  | pbit_val written to state[i]; advance p-bit / sweep
// FIN    | end of run; done is raised next cycle
module pbit_gibbs_sched #(
  parameter int N          = 8,
  parameter int INT_SIZE   = 8,
  parameter int FLOAT_SIZE = 24,
  parameter int PBIT_LAT   = 2,
  parameter int ADDR_W     = 7,
  parameter int SWEEP_W    = 16
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      start,
  input  logic [SWEEP_W-1:0]                        num_sweeps,
  input  logic [N-1:0]                              init_state,
  output logic                                      coef_rd,
  output logic [ADDR_W-1:0]                         coef_addr,
  input  logic signed [INT_SIZE+FLOAT_SIZE-1:0]     coef_data,
  output logic signed [INT_SIZE+FLOAT_SIZE-1:0]     z,
  output logic                                      z_valid,
  input  logic                                      pbit_val,
  output logic [N-1:0]                              state,
  output logic                                      busy,
  output logic                                      done
);

  localparam int W      = INT_SIZE + FLOAT_SIZE;
  localparam int ACC_W  = W + $clog2(N + 1) + 1;
  localparam int WIDX_W = $clog2(N + 1);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int TMR_W  = $clog2(N + PBIT_LAT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SETTLE, LATCH, FIN} st_t;

  st_t                      cur_st, nxt_st;
  logic [TMR_W-1:0]         tmr;
  logic [IDX_W-1:0]         idx;
  logic [SWEEP_W-1:0]       sweeps_left;
  logic signed [ACC_W-1:0]  acc;
  logic                     rd_q;
  logic [WIDX_W-1:0]        widx_q;

  logic [WIDX_W-1:0]        widx_cur;
  logic [N:0]               spin_ext;
  logic signed [ACC_W-1:0]  data_ext;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [W-1:0]      z_sat;
  logic                     last_bit;
  logic                     last_sweep;

  assign last_bit   = (idx == IDX_W'(N - 1));
  assign last_sweep = (sweeps_left == SWEEP_W'(1));

  // Word index of the read in flight; tmr counts down N..0 across FETCH.
  // Bit 0 of spin_ext is a constant 1 so the bias (word 0) is always added,
  // and word k (k>=1) picks up the sign of state[k-1].
  always_comb begin
    widx_cur = WIDX_W'(N) - WIDX_W'(tmr);
    spin_ext = {state, 1'b1};
    data_ext = {{(ACC_W - W){coef_data[W-1]}}, coef_data};
    term     = spin_ext[widx_q] ? data_ext : -data_ext;
    acc_sum  = acc + term;
    if (acc_sum[ACC_W-1:W-1] == {(ACC_W - W + 1){acc_sum[ACC_W-1]}})
      z_sat = acc_sum[W-1:0];
    else if (acc_sum[ACC_W-1])
      z_sat = {1'b1, {(W - 1){1'b0}}};
    else
      z_sat = {1'b0, {(W - 1){1'b1}}};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cur_st <= IDLE;
    else      cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      IDLE:   if (start) nxt_st = (num_sweeps == '0) ? FIN : FETCH;
      FETCH:  if (tmr == '0) nxt_st = DRAIN;
      DRAIN:  nxt_st = SETTLE;
      SETTLE: if (tmr == '0) nxt_st = LATCH;
      LATCH:  nxt_st = (last_bit && last_sweep) ? FIN : FETCH;
      FIN:    nxt_st = IDLE;
      default: nxt_st = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= '0;
      z           <= '0;
      z_valid     <= 1'b0;
      coef_rd     <= 1'b0;
      coef_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tmr         <= '0;
      idx         <= '0;
      sweeps_left <= '0;
      acc         <= '0;
      rd_q        <= 1'b0;
      widx_q      <= '0;
    end else begin
      done   <= 1'b0;
      rd_q   <= coef_rd;
      widx_q <= widx_cur;
      if (rd_q) acc <= acc_sum;

      case (cur_st)
        IDLE: begin
          if (start) begin
            state       <= init_state;
            busy        <= 1'b1;
            idx         <= '0;
            sweeps_left <= num_sweeps;
            coef_addr   <= '0;
            acc         <= '0;
            if (num_sweeps != '0) begin
              coef_rd <= 1'b1;
              tmr     <= TMR_W'(N);
            end
          end
        end
        FETCH: begin
          // Rows are contiguous, so the address just keeps incrementing.
          coef_addr <= coef_addr + ADDR_W'(1);
          if (tmr == '0) coef_rd <= 1'b0;
          else           tmr     <= tmr - TMR_W'(1);
        end
        DRAIN: begin
          z       <= z_sat;
          z_valid <= 1'b1;
          tmr     <= TMR_W'(PBIT_LAT - 1);
        end
        SETTLE: begin
          // Drop z_valid as LATCH is entered so it is high for PBIT_LAT cycles.
          if (tmr == '0) z_valid <= 1'b0;
          else           tmr     <= tmr - TMR_W'(1);
        end
        LATCH: begin
          state[idx] <= pbit_val;
          acc        <= '0;
          z_valid    <= 1'b0;
          if (last_bit) begin
            idx         <= '0;
            coef_addr   <= '0;
            sweeps_left <= sweeps_left - SWEEP_W'(1);
            if (!last_sweep) begin
              coef_rd <= 1'b1;
              tmr     <= TMR_W'(N);
            end
          end else begin
            idx     <= idx + IDX_W'(1);
            coef_rd <= 1'b1;
            tmr     <= TMR_W'(N);
          end
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_gibbs_sched.sv
module tb_pbit_gibbs_sched;

  localparam int N  = 4;
  localparam int PL = 2;
  localparam int AW = 7;
  localparam int SW = 16;
  localparam int W  = 32;
  localparam int MW = N * (N + 1);
  localparam longint ZMAX = 64'sd2147483647;
  localparam longint ZMIN = -ZMAX - 1;

  logic                CLK = 1'b0;
  logic                RST;
  logic                start;
  logic [SW-1:0]       num_sweeps;
  logic [N-1:0]        init_state;
  logic                coef_rd;
  logic [AW-1:0]       coef_addr;
  logic signed [W-1:0] coef_data;
  logic signed [W-1:0] z;
  logic                z_valid;
  logic                pbit_val;
  logic [N-1:0]        state;
  logic                busy;
  logic                done;

  pbit_gibbs_sched #(
    .N(N), .INT_SIZE(8), .FLOAT_SIZE(24), .PBIT_LAT(PL), .ADDR_W(AW), .SWEEP_W(SW)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .num_sweeps(num_sweeps),
    .init_state(init_state), .coef_rd(coef_rd), .coef_addr(coef_addr),
    .coef_data(coef_data), .z(z), .z_valid(z_valid), .pbit_val(pbit_val),
    .state(state), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Coefficient RAM: registered read, data one cycle after coef_rd.
  logic [W-1:0] mem [0:MW-1];
  always @(posedge CLK) if (coef_rd) coef_data <= mem[coef_addr];

  // Deterministic pbit stand-in: outputs 1 when z >= 0, two-stage pipeline.
  // Random output whenever z_valid is low, so mistimed sampling shows up.
  logic p1 = 1'b0, p2 = 1'b0;
  always @(posedge CLK) begin
    p1 <= z_valid ? ~z[W-1] : 1'($urandom);
    p2 <= p1;
  end
  assign pbit_val = p2;

  int n_err = 0;
  int n_checks = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected behaviour, built up front for each run.
  logic [AW-1:0] exp_addr[$];
  logic [W-1:0]  exp_z[$];
  logic [N-1:0]  exp_pre[$];

  task automatic model_run(input logic [N-1:0] init, input int ns, output logic [N-1:0] fin);
    logic [N-1:0] s;
    longint sum, jv;
    logic [W-1:0] zexp;
    int base;
    s = init;
    for (int sw = 0; sw < ns; sw++) begin
      for (int i = 0; i < N; i++) begin
        base = i * (N + 1);
        for (int k = 0; k <= N; k++) begin
          int a;
          a = base + k;
          exp_addr.push_back(a[AW-1:0]);
        end
        sum = longint'($signed(mem[base]));
        for (int j = 0; j < N; j++) begin
          jv = longint'($signed(mem[base + 1 + j]));
          sum = s[j] ? sum + jv : sum - jv;
        end
        if (sum > ZMAX)      zexp = 32'h7FFF_FFFF;
        else if (sum < ZMIN) zexp = 32'h8000_0000;
        else                 zexp = sum[W-1:0];
        exp_pre.push_back(s);
        exp_z.push_back(zexp);
        s[i] = ~zexp[W-1];
      end
    end
    fin = s;
  endtask

  // Per-cycle compare against the model queues.
  bit            mon_en = 1'b0;
  int            rd_run, zv_run, zcount, rd_total;
  logic [W-1:0]  first_z, hold_z, ez;
  logic [AW-1:0] ea;
  logic [N-1:0]  es;

  always @(negedge CLK) begin
    if (mon_en && RST) begin
      if (coef_rd) begin
        rd_total++;
        rd_run++;
        chk("coef_addr_expected", exp_addr.size() != 0, coef_addr, 0);
        if (exp_addr.size() != 0) begin
          ea = exp_addr.pop_front();
          chk("coef_addr", coef_addr == ea, coef_addr, ea);
        end
      end else if (rd_run != 0) begin
        chk("rd_burst_len", rd_run == N + 1, rd_run, N + 1);
        rd_run = 0;
      end
      if (z_valid) begin
        if (zv_run == 0) begin
          chk("z_expected", exp_z.size() != 0, z, 0);
          if (exp_z.size() != 0) begin
            ez = exp_z.pop_front();
            es = exp_pre.pop_front();
            chk("z", z == ez, z, ez);
            chk("state_pre", state == es, state, es);
          end
          if (zcount == 0) first_z = z;
          zcount++;
          hold_z = z;
        end else begin
          chk("z_hold", z == hold_z, z, hold_z);
        end
        zv_run++;
      end else if (zv_run != 0) begin
        chk("zvalid_len", zv_run == PL, zv_run, PL);
        zv_run = 0;
      end
    end
  end

  task automatic fill(input logic [W-1:0] h, input logic [W-1:0] j);
    for (int a = 0; a < MW; a++) mem[a] = ((a % (N + 1)) == 0) ? h : j;
  endtask

  task automatic run(input string tag, input logic [N-1:0] init, input int ns, input bit inject);
    logic [N-1:0] mfin;
    int k, exp_lat;
    bit got;
    exp_addr.delete(); exp_z.delete(); exp_pre.delete();
    model_run(init, ns, mfin);
    zcount = 0; rd_total = 0; rd_run = 0; zv_run = 0;
    exp_lat = 2 + ns * N * (N + PL + 3);
    @(posedge CLK); #1;
    init_state = init; num_sweeps = SW'(ns); start = 1'b1; mon_en = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; init_state = ~init; num_sweeps = '1;
    k = 1; got = 1'b0;
    while (!got && k < 3000) begin
      @(negedge CLK);
      if (done) got = 1'b1;
      else begin
        chk({tag, "_busy"}, busy == 1'b1, busy, 1);
        start = inject && (k == 10);
        @(posedge CLK);
        k++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, got, got, 1);
    chk({tag, "_latency"}, k == exp_lat, k, exp_lat);
    chk({tag, "_state"}, state == mfin, state, mfin);
    chk({tag, "_busy_low"}, busy == 1'b0, busy, 0);
    chk({tag, "_z_left"}, exp_z.size() == 0, exp_z.size(), 0);
    chk({tag, "_addr_left"}, exp_addr.size() == 0, exp_addr.size(), 0);
    mon_en = 1'b0;
    @(negedge CLK);
    chk({tag, "_done_pulse"}, done == 1'b0, done, 0);
  endtask

  initial begin
    int ndone, nbusy;
    RST = 1'b0; start = 1'b0; num_sweeps = '0; init_state = '0;
    fill('0, '0);
    repeat (2) @(negedge CLK);
    chk("rst_state", state == '0, state, 0);
    chk("rst_z", z == '0, z, 0);
    chk("rst_z_valid", z_valid == 1'b0, z_valid, 0);
    chk("rst_coef_rd", coef_rd == 1'b0, coef_rd, 0);
    chk("rst_coef_addr", coef_addr == '0, coef_addr, 0);
    chk("rst_busy", busy == 1'b0, busy, 0);
    chk("rst_done", done == 1'b0, done, 0);
    RST = 1'b1;

    // Strong positive bias, no coupling -> all spins +1.
    fill(32'h7F00_0000, 32'h0);
    run("t1", 4'b0000, 1, 1'b0);
    chk("t1_lit_state", state == 4'b1111, state, 4'b1111);

    // Strong negative bias -> all spins -1.
    fill(32'h8000_0000, 32'h0);
    run("t2", 4'b1111, 1, 1'b0);
    chk("t2_lit_state", state == 4'b0000, state, 4'b0000);

    // Mixed couplings, two sweeps, with a stray start mid-run.
    mem[0]  = 32'h0080_0000; mem[1]  = 32'h0100_0000; mem[2]  = 32'h0200_0000;
    mem[3]  = 32'h0300_0000; mem[4]  = 32'h0400_0000;
    mem[5]  = 32'h0040_0000; mem[6]  = 32'hFF00_0000; mem[7]  = 32'h0080_0000;
    mem[8]  = 32'hFE00_0000; mem[9]  = 32'h0100_0000;
    mem[10] = 32'hFF80_0000; mem[11] = 32'h00C0_0000; mem[12] = 32'hFF40_0000;
    mem[13] = 32'h0020_0000; mem[14] = 32'hFFE0_0000;
    mem[15] = 32'h0000_0000; mem[16] = 32'h0180_0000; mem[17] = 32'hFE80_0000;
    mem[18] = 32'h0040_0000; mem[19] = 32'hFF00_0000;
    run("t3", 4'b1010, 2, 1'b1);
    chk("t3_lit_first_z", first_z == 32'h0280_0000, first_z, 32'h0280_0000);

    // Positive saturation.
    fill(32'h7F00_0000, 32'h7F00_0000);
    run("t4", 4'b1111, 1, 1'b0);
    chk("t4_lit_first_z", first_z == 32'h7FFF_FFFF, first_z, 32'h7FFF_FFFF);

    // Negative saturation.
    fill(32'h8000_0000, 32'h8000_0000);
    run("t4b", 4'b1111, 1, 1'b0);
    chk("t4b_lit_first_z", first_z == 32'h8000_0000, first_z, 32'h8000_0000);

    // Zero sweeps: just loads state and finishes.
    run("t5", 4'b0110, 0, 1'b0);
    chk("t5_lit_state", state == 4'b0110, state, 4'b0110);
    chk("t5_no_rd", rd_total == 0, rd_total, 0);

    // Reset in the middle of FETCH.
    fill(32'h7F00_0000, 32'h0);
    @(posedge CLK); #1;
    init_state = 4'b1111; num_sweeps = 16'd1; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    @(posedge CLK); @(posedge CLK); #2;
    chk("t6_pre_busy", busy == 1'b1, busy, 1);
    chk("t6_pre_rd", coef_rd == 1'b1, coef_rd, 1);
    chk("t6_pre_state", state == 4'b1111, state, 4'b1111);
    RST = 1'b0; #1;
    chk("t6_busy", busy == 1'b0, busy, 0);
    chk("t6_rd", coef_rd == 1'b0, coef_rd, 0);
    chk("t6_zv", z_valid == 1'b0, z_valid, 0);
    chk("t6_state", state == '0, state, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    ndone = 0; nbusy = 0;
    repeat (60) begin
      @(negedge CLK);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("t6_no_done", ndone == 0, ndone, 0);
    chk("t6_no_busy", nbusy == 0, nbusy, 0);

    // Normal run after the abort.
    fill(32'h8000_0000, 32'h0100_0000);
    run("t7", 4'b0101, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pbit_gibbs_sched.md
Name: pbit_gibbs_sched

Overview:
- Sequential Gibbs-sampling scheduler that time-shares one pbit datapath (tanh + RNG + compare) across N logical p-bits.
- For each p-bit i, in order, it:
  - fetches the bias and coupling row from an external coefficient RAM,
  - accumulates the local field z_i in Q8.24,
  - drives z_i into the shared pbit,
  - waits the pbit pipeline latency,
  - latches pbit_val as the new state bit m_i.
- Runs a programmable number of full sweeps, then pulses done.

Parameters:
- N, 8, number of logical p-bits.
- INT_SIZE, 8, integer bits of the Q format of z and of the coefficients.
- FLOAT_SIZE, 24, fractional bits (word width W = INT_SIZE+FLOAT_SIZE = 32).
- PBIT_LAT, 2, cycles from z presented to a valid pbit_val (must be >= 1).
- ADDR_W, 7, coefficient address width (must be >= clog2(N*(N+1))).
- SWEEP_W, 16, width of the sweep count.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a run when idle.
- num_sweeps  in  SWEEP_W  sweeps to run; sampled on start.
- init_state  in  N  initial spin vector; sampled on start.
- coef_rd  out  1  coefficient read strobe.
- coef_addr  out  ADDR_W  coefficient address.
- coef_data  in  W  signed Q8.24 read data, valid exactly 1 cycle after coef_rd.
- z  out  W  signed Q8.24 local field to the pbit.
- z_valid  out  1  high while z is held for the pbit.
- pbit_val  in  1  pbit output.
- state  out  N  current spin vector (bit=1 means +1, bit=0 means -1).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset values (all asserted asynchronously, released synchronously): state=0, z=0, z_valid=0, coef_rd=0, coef_addr=0, busy=0, done=0; FSM goes to IDLE; all counters are cleared.
- Coefficient memory layout:
  - Row i occupies addresses i*(N+1) .. i*(N+1)+N.
  - Word 0 of the row is bias h_i; words 1..N are J_i0..J_i(N-1).
  - The address is produced by an incrementing counter; no multiplier is used.
  - J_ii is used exactly as stored.
- FSM states: IDLE, FETCH, DRAIN, SETTLE, LATCH, FIN.
- IDLE:
  - start=1 with num_sweeps!=0: load state<=init_state; clear i, sweep count, address and accumulator; go to FETCH; busy=1.
  - start=1 with num_sweeps=0: load state<=init_state; go to FIN; no coef_rd is issued.
- FETCH (N+1 cycles):
  - coef_rd=1; coef_addr steps through row i.
  - Each returned word is added to the accumulator, with sign from the current state bit: bias is always added; J_ij is added if state[j]=1, subtracted if state[j]=0.
- DRAIN (1 cycle): accumulate the last word; z <= sat(acc); z_valid <= 1.
- Accumulator: W+clog2(N+1)+1 bits signed. sat() clamps to 0x7FFFFFFF / 0x80000000.
- SETTLE (PBIT_LAT cycles): hold z and z_valid.
- LATCH (1 cycle):
  - state[i] <= pbit_val; z_valid <= 0; clear the accumulator.
  - If i<N-1: i++, go to FETCH.
  - Else: i=0 and sweep++. If sweep==num_sweeps go to FIN, else go to FETCH.
- FIN (1 cycle): done=1, busy=0, then IDLE.
- Cycles per p-bit = N+PBIT_LAT+3. Start-to-done = 1 + num_sweeps*N*(N+PBIT_LAT+3) + 1.
- The updated state[i] is used by all later fetches (true sequential Gibbs).
- start while busy is ignored. Inputs are sampled only on an accepted start.
- Asserting RST mid-run aborts immediately; no done pulse is produced.
- The sweep counter does not wrap: the run always terminates at num_sweeps.

Test Plan:
1. N=4, PBIT_LAT=2, all J=0, all bias=0x7F000000, num_sweeps=1 -> state=4'b1111; done exactly 38 cycles after start; coef_rd high for 5 consecutive cycles per p-bit.
2. Same as 1 with all bias=0x80000000 and init_state=4'b1111 -> state=4'b0000 after one sweep.
3. init_state=4'b1010, row 0 = {h=0x00800000, J=1.0,2.0,3.0,4.0} -> first z_valid shows z=0x02800000 (-1+2-3+4+0.5), held for exactly PBIT_LAT cycles.
4. All J=0x7F000000, all bias=0x7F000000, init_state=4'b1111 -> z=0x7FFFFFFF (saturated), with no wrap to negative.
5. num_sweeps=0, init_state=4'b0110 -> done 2 cycles after start; state=4'b0110; coef_rd never asserted.
6. Second start pulse mid-run -> ignored, run completes normally. RST low mid-FETCH -> busy, coef_rd, z_valid and state are 0 in the same cycle; no done pulse.
